edge_conv3x3: RTL and testbench
===============================

# edge_conv3x3

Parametrised 3x3 gradient edge detector for the sobel pipeline, the successor to the fixed 8-bit Sobel convolver. It takes a 3x3 window from the line-buffer stage and applies one of three kernels (Sobel, Prewitt, Scharr). It computes an L2-squared or L1 gradient magnitude and emits either a thresholded binary pixel or a saturated grey magnitude. It adds valid/ready backpressure, per-pixel mode capture, and a running edge-pixel counter for frame statistics.

## Interface
- PIX_W, 8: pixel width in bits (4..12).
- CNT_W, 24: edge counter width.
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- Threshhold_in  in  PIX_W  edge threshold, unsigned.
- Kern_sel_in  in  2  kernel: 0 Sobel, 1 Prewitt, 2 Scharr, 3 treated as Sobel.
- Mag_sel_in  in  1  0 = L2 (Gx²+Gy²), 1 = L1 (|Gx|+|Gy|).
- Out_sel_in  in  1  0 = binary output, 1 = grey magnitude output.
- pixel_data_in  in  9*PIX_W  window; p[i] = bits [i*PIX_W +: PIX_W], row-major, p0 top-left, p8 bottom-right.
- pixel_data_valid_in  in  1  window valid.
- pixel_ready_out  out  1  block accepts the window this cycle.
- conv_data_out  out  PIX_W  result pixel.
- conv_data_valid_out  out  1  result valid.
- conv_ready_in  in  1  downstream accepts the result.
- Cnt_clr_in  in  1  synchronous clear of the edge counter.
- Edge_cnt_out  out  CNT_W  count of accepted binary outputs equal to all-ones.

## Operation
- Transfer in: pixel_data_valid_in & pixel_ready_out. Transfer out: conv_data_valid_out & conv_ready_in.
- Kern_sel_in, Mag_sel_in, Out_sel_in and Threshhold_in are captured with each accepted window and travel down the pipeline with it. Changing them mid-stream affects only windows accepted afterwards.
- Kernel column weights are (a, b, a): Sobel (1,2,1), Prewitt (1,1,1), Scharr (3,10,3).
- Gx = a·p0 + b·p3 + a·p6 − a·p2 − b·p5 − a·p8.
- Gy = a·p0 + b·p1 + a·p2 − a·p6 − b·p7 − a·p8.
- Width rules:
  - Gx and Gy are signed, PIX_W+5 bits; no overflow is possible, since the Scharr maximum is 16·(2^PIX_W−1).
  - Squares are unsigned, 2·(PIX_W+4) bits. Gt = Gx²+Gy² is one bit wider.
  - L1 is unsigned, PIX_W+6 bits.
- Binary mode:
  - L2: output all-ones iff Gt > Th·Th (strict).
  - L1: output all-ones iff L1 > Th (strict).
  - Otherwise the output is 0.
- Grey mode:
  - L1: output min(L1, 2^PIX_W−1).
  - L2: output min(Gt >> PIX_W, 2^PIX_W−1).
- Edge counter:
  - Increments by 1 on each output transfer carrying a binary-mode all-ones result.
  - Grey-mode outputs never count.
  - Wraps at 2^CNT_W.
  - Cnt_clr_in has priority over a simultaneous increment; the counter becomes 0.

## Timing
- Four register stages:
  - S1: coefficient products.
  - S2: Gx/Gy sums.
  - S3: squares, abs and L1.
  - S4: compare/saturate into conv_data_out.
- Latency: 4 cycles from input transfer to conv_data_valid_out with no stall.
- Throughput: one window per cycle.
- Global stall: advance = ~conv_data_valid_out | conv_ready_in.
  - pixel_ready_out = advance (combinational).
  - When advance is 0, all stages and their valid bits hold.
  - No bubble collapsing is required.
- While stalled, conv_data_out and conv_data_valid_out hold stable.
- A bubble (valid 0) propagates as valid 0. Data registers in bubble stages are don't-care, but conv_data_out changes only when a valid result loads.
- Reset (async assert, sync release) clears all stage valids, conv_data_valid_out, conv_data_out and Edge_cnt_out to 0.
  - Reset mid-stream discards in-flight windows.
  - pixel_ready_out is 1 in the first cycle after reset.
- Simultaneous input and output transfer in the same cycle is normal streaming and must lose nothing.

## Test plan
- Flat field: all p = 100, Sobel, L2, binary, Th = 1. Required: conv_data_out = 0x00 four cycles later; Edge_cnt_out stays 0.
- Vertical edge: p0 = p3 = p6 = 255, others 0, Th = 255, L2, binary, each of Sobel/Prewitt/Scharr in turn (Gx = 1020 / 765 / 4080, Gy = 0). Required: 0xFF each time. With grey L1, required: 0xFF each time (saturated).
- Threshold boundary: p3 = 10, others 0, Sobel, L2 (Gx = 20, Gt = 400). Required: Th = 20 gives 0x00; Th = 19 gives 0xFF. With L1, required: Th = 20 gives 0x00; Th = 19 gives 0xFF.
- Backpressure: stream 8 distinct windows back-to-back while holding conv_ready_in low for 3 cycles mid-stream. Required: all 8 results emerge in order, none duplicated; output is stable during the stall; pixel_ready_out is low exactly while the output is valid and not ready.
- Per-pixel mode: alternate Kern_sel_in 0/2 on consecutive windows carrying the vertical edge, grey L1 mode, PIX_W = 12. Required: outputs alternate 1020 and 4080.
- Counter and reset: 5 binary edge outputs, then Cnt_clr_in concurrent with a 6th edge transfer, then 2 more. Required: count reaches 5, then 0, then 2. Assert Rst with 3 windows in flight: required: all outputs are 0 next cycle and no stale results appear after release.

Source files
------------

// File: rtl/edge_conv3x3.sv
// edge_conv3x3: four-stage 3x3 gradient edge detector (Sobel / Prewitt / Scharr)
// with L2-squared or L1 magnitude, binary or saturated grey output, a single
// global stall for valid/ready backpressure and a running edge-pixel counter.
module edge_conv3x3 #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 24
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [PIX_W-1:0]   Threshhold_in,
  input  logic [1:0]         Kern_sel_in,
  input  logic               Mag_sel_in,
  input  logic               Out_sel_in,
  input  logic [9*PIX_W-1:0] pixel_data_in,
  input  logic               pixel_data_valid_in,
  output logic               pixel_ready_out,
  output logic [PIX_W-1:0]   conv_data_out,
  output logic               conv_data_valid_out,
  input  logic               conv_ready_in,
  input  logic               Cnt_clr_in,
  output logic [CNT_W-1:0]   Edge_cnt_out
);

  localparam int PRW = PIX_W + 4;         // single weighted tap
  localparam int GW  = PIX_W + 5;         // signed Gx / Gy
  localparam int SQW = 2 * (PIX_W + 4);   // one square
  localparam int GTW = SQW + 1;           // Gx^2 + Gy^2
  localparam int L1W = PIX_W + 6;         // |Gx| + |Gy|

  // Per-window mode that travels with the data down to the output stage
  typedef struct packed {
    logic             mag;
    logic             outSel;
    logic [PIX_W-1:0] th;
  } mode_t;

  logic advance;
  logic [3:0] wA, wB;
  logic unusedCenter;

  logic [PRW-1:0] cornerProd_d [4];
  logic [PRW-1:0] edgeProd_d [4];
  logic [PRW-1:0] cornerProd_q [4];
  logic [PRW-1:0] edgeProd_q [4];
  logic           valid1_q, valid2_q, valid3_q, convValid_q;
  mode_t          mode1_q, mode2_q, mode3_q;

  logic [GW-1:0]        posX, negX, posY, negY;
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;

  logic [GW-1:0]  absX, absY;
  logic [SQW-1:0] sqX, sqY;
  logic [GTW-1:0] gt_d, gt_q;
  logic [L1W-1:0] l1_d, l1_q;

  logic [PIX_W-1:0] pixMax, greyL1, greyL2, result_d, convData_q;
  logic [GTW-1:0]   thSq, gtShift;
  logic             isEdge, edgeHit_d, edgeHit_q;
  logic [CNT_W-1:0] edgeCnt_q;

  assign advance             = ~convValid_q | conv_ready_in;
  assign pixel_ready_out     = advance;
  assign conv_data_out       = convData_q;
  assign conv_data_valid_out = convValid_q;
  assign Edge_cnt_out        = edgeCnt_q;

  // The centre tap carries zero weight in every kernel, so its pixel is never used
  assign unusedCenter = ^pixel_data_in[4*PIX_W +: PIX_W];

  // Column weights (a, b, a) for the selected kernel; code 3 falls back to Sobel
  always_comb begin
    wA = 4'd1;
    wB = 4'd2;
    case (Kern_sel_in)
      2'd1: begin wA = 4'd1; wB = 4'd1;  end
      2'd2: begin wA = 4'd3; wB = 4'd10; end
      default: begin wA = 4'd1; wB = 4'd2; end
    endcase
  end

  // Corners p0,p2,p6,p8 take weight a; edge-centres p1,p3,p5,p7 take weight b
  for (genvar k = 0; k < 4; k++) begin : gProd
    localparam int CI = (k < 2) ? 2 * k : 2 * k + 2;
    localparam int EI = 2 * k + 1;
    assign cornerProd_d[k] = PRW'(pixel_data_in[CI*PIX_W +: PIX_W]) * PRW'(wA);
    assign edgeProd_d[k]   = PRW'(pixel_data_in[EI*PIX_W +: PIX_W]) * PRW'(wB);
  end

  // S1: register the weighted taps and capture the mode of the accepted window
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid1_q <= 1'b0;
      mode1_q  <= '0;
      for (int k = 0; k < 4; k++) begin
        cornerProd_q[k] <= '0;
        edgeProd_q[k]   <= '0;
      end
    end else if (advance) begin
      valid1_q     <= pixel_data_valid_in;
      mode1_q      <= '{mag: Mag_sel_in, outSel: Out_sel_in, th: Threshhold_in};
      cornerProd_q <= cornerProd_d;
      edgeProd_q   <= edgeProd_d;
    end
  end

  // Gx = left column minus right column, Gy = top row minus bottom row
  always_comb begin
    posX = GW'(cornerProd_q[0]) + GW'(edgeProd_q[1]) + GW'(cornerProd_q[2]);
    negX = GW'(cornerProd_q[1]) + GW'(edgeProd_q[2]) + GW'(cornerProd_q[3]);
    posY = GW'(cornerProd_q[0]) + GW'(edgeProd_q[0]) + GW'(cornerProd_q[1]);
    negY = GW'(cornerProd_q[2]) + GW'(edgeProd_q[3]) + GW'(cornerProd_q[3]);
    gx_d = $signed(posX - negX);
    gy_d = $signed(posY - negY);
  end

  // S2: register the signed gradients
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid2_q <= 1'b0;
      mode2_q  <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
    end else if (advance) begin
      valid2_q <= valid1_q;
      mode2_q  <= mode1_q;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
    end
  end

  // Magnitudes: squares feed the L2 sum, absolute values feed the L1 sum
  always_comb begin
    absX = gx_q[GW-1] ? -gx_q : gx_q;
    absY = gy_q[GW-1] ? -gy_q : gy_q;
    sqX  = SQW'(absX) * SQW'(absX);
    sqY  = SQW'(absY) * SQW'(absY);
    gt_d = GTW'(sqX) + GTW'(sqY);
    l1_d = L1W'(absX) + L1W'(absY);
  end

  // S3: register both magnitudes so the output stage can pick either
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid3_q <= 1'b0;
      mode3_q  <= '0;
      gt_q     <= '0;
      l1_q     <= '0;
    end else if (advance) begin
      valid3_q <= valid2_q;
      mode3_q  <= mode2_q;
      gt_q     <= gt_d;
      l1_q     <= l1_d;
    end
  end

  // Threshold compare (strict) and grey saturation for the selected magnitude
  always_comb begin
    pixMax    = {PIX_W{1'b1}};
    thSq      = GTW'(mode3_q.th) * GTW'(mode3_q.th);
    gtShift   = gt_q >> PIX_W;
    greyL1    = (l1_q > L1W'(pixMax)) ? pixMax : l1_q[PIX_W-1:0];
    greyL2    = (gtShift > GTW'(pixMax)) ? pixMax : gtShift[PIX_W-1:0];
    isEdge    = mode3_q.mag ? (l1_q > L1W'(mode3_q.th)) : (gt_q > thSq);
    edgeHit_d = ~mode3_q.outSel & isEdge;
    if (mode3_q.outSel)
      result_d = mode3_q.mag ? greyL1 : greyL2;
    else
      result_d = isEdge ? pixMax : '0;
  end

  // S4: output register; data only reloads when a valid result arrives
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      convValid_q <= 1'b0;
      convData_q  <= '0;
      edgeHit_q   <= 1'b0;
    end else if (advance) begin
      convValid_q <= valid3_q;
      if (valid3_q) begin
        convData_q <= result_d;
        edgeHit_q  <= edgeHit_d;
      end
    end
  end

  // Edge counter: counts transferred binary edge pixels, clear wins over increment
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      edgeCnt_q <= '0;
    else if (Cnt_clr_in)
      edgeCnt_q <= '0;
    else if (convValid_q & conv_ready_in & edgeHit_q)
      edgeCnt_q <= edgeCnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_edge_conv3x3.sv
// tb_edge_conv3x3: directed table of windows with hand-computed results for an
// 8-bit instance, plus streaming, stall, counter and reset sequences and a
// 12-bit instance for per-window kernel switching.
module tb_edge_conv3x3;

  typedef logic [8:0][7:0]  win_t;
  typedef logic [8:0][11:0] win12_t;

  typedef struct {
    string      name;
    logic [1:0] kern;
    logic       mag;
    logic       outSel;
    logic [7:0] th;
    win_t       win;
    logic [7:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  th;
  logic [1:0]  kern;
  logic        mag, outSel;
  win_t        pixData;
  logic        pixValid, pixReady;
  logic [7:0]  convData;
  logic        convValid, convReady, cntClr;
  logic [23:0] edgeCnt;

  logic [11:0] th12;
  logic [1:0]  kern12;
  logic        mag12, outSel12;
  win12_t      pixData12;
  logic        pixValid12, pixReady12;
  logic [11:0] convData12;
  logic        convValid12, convReady12, cntClr12;
  logic [23:0] edgeCnt12;

  int   vecCount = 0;
  int   missCount = 0;
  int   expCnt = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  edge_conv3x3 #(.PIX_W(8), .CNT_W(24)) dut (
    .Clk(clk), .Rst(rst), .Threshhold_in(th), .Kern_sel_in(kern),
    .Mag_sel_in(mag), .Out_sel_in(outSel), .pixel_data_in(pixData),
    .pixel_data_valid_in(pixValid), .pixel_ready_out(pixReady),
    .conv_data_out(convData), .conv_data_valid_out(convValid),
    .conv_ready_in(convReady), .Cnt_clr_in(cntClr), .Edge_cnt_out(edgeCnt)
  );

  edge_conv3x3 #(.PIX_W(12), .CNT_W(24)) dut12 (
    .Clk(clk), .Rst(rst), .Threshhold_in(th12), .Kern_sel_in(kern12),
    .Mag_sel_in(mag12), .Out_sel_in(outSel12), .pixel_data_in(pixData12),
    .pixel_data_valid_in(pixValid12), .pixel_ready_out(pixReady12),
    .conv_data_out(convData12), .conv_data_valid_out(convValid12),
    .conv_ready_in(convReady12), .Cnt_clr_in(cntClr12), .Edge_cnt_out(edgeCnt12)
  );

  function automatic win_t mk(input int q0, q1, q2, q3, q4, q5, q6, q7, q8);
    win_t w;
    w[0] = 8'(q0); w[1] = 8'(q1); w[2] = 8'(q2);
    w[3] = 8'(q3); w[4] = 8'(q4); w[5] = 8'(q5);
    w[6] = 8'(q6); w[7] = 8'(q7); w[8] = 8'(q8);
    return w;
  endfunction

  task automatic addVec(input string name, input int k, input int m, input int o,
                        input int t, input win_t w, input int e);
    vec_t v;
    v.name = name; v.kern = 2'(k); v.mag = 1'(m); v.outSel = 1'(o);
    v.th = 8'(t); v.win = w; v.exp = 8'(e);
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  // One isolated window: accept, latency, result, no duplicate, edge count
  task automatic applyStimulus(input vec_t v, input bit clrAtXfer);
    int lat;
    @(negedge clk);
    kern = v.kern; mag = v.mag; outSel = v.outSel; th = v.th;
    pixData = v.win; pixValid = 1'b1;
    #1 checkOutput({v.name, " ready"}, pixReady, 1);
    lat = 1;
    @(negedge clk);
    pixValid = 1'b0;
    while (!convValid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({v.name, " latency"}, lat, 4);
    checkOutput({v.name, " data"}, convData, v.exp);
    if (!v.outSel && v.exp == 8'hFF) expCnt++;
    if (clrAtXfer) begin
      cntClr = 1'b1;
      expCnt = 0;
    end
    @(negedge clk);
    cntClr = 1'b0;
    checkOutput({v.name, " single output"}, convValid, 0);
    checkOutput({v.name, " edge count"}, edgeCnt, expCnt);
  endtask

  // Eight back-to-back windows with the consumer stalled for three cycles
  task automatic backpressureRun();
    int idx, outIdx, stallCycles;
    idx = 0; outIdx = 0; stallCycles = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      convReady = !(cyc >= 6 && cyc <= 8);
      kern = 2'd0; mag = 1'b1; outSel = 1'b1; th = 8'd0;
      pixValid = (idx < 8);
      pixData = mk(0, 0, 0, 10 * (idx + 1), 0, 0, 0, 0, 0);
      #1;
      checkOutput("bp ready", pixReady, !(convValid && !convReady));
      if (convValid) begin
        if (outIdx < 8) checkOutput("bp data", convData, 20 * (outIdx + 1));
        else checkOutput("bp extra output index", outIdx, 7);
        if (convReady) outIdx++;
        else stallCycles++;
      end
      if (pixValid && pixReady) idx++;
    end
    @(negedge clk);
    pixValid = 1'b0; convReady = 1'b1;
    checkOutput("bp windows accepted", idx, 8);
    checkOutput("bp results delivered", outIdx, 8);
    checkOutput("bp stalled cycles", stallCycles, 3);
  endtask

  // 12-bit instance: kernel alternates Sobel/Scharr on consecutive windows
  task automatic perPixelRun();
    int idx, outIdx;
    idx = 0; outIdx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      pixValid12 = (idx < 6);
      kern12 = (idx % 2 == 0) ? 2'd0 : 2'd2;
      pixData12 = '0;
      pixData12[0] = 12'd255; pixData12[3] = 12'd255; pixData12[6] = 12'd255;
      #1;
      if (convValid12) begin
        if (outIdx < 6) checkOutput("kern alt data", convData12, (outIdx % 2 == 0) ? 1020 : 4080);
        else checkOutput("kern alt extra output index", outIdx, 5);
        outIdx++;
      end
      if (pixValid12 && pixReady12) idx++;
    end
    pixValid12 = 1'b0;
    checkOutput("kern alt results", outIdx, 6);
  endtask

  // Three windows in flight when reset hits; nothing may emerge afterwards
  task automatic resetRun();
    int seen;
    @(negedge clk);
    kern = 2'd0; mag = 1'b0; outSel = 1'b0; th = 8'd255;
    pixData = mk(255, 0, 0, 255, 0, 0, 255, 0, 0);
    pixValid = 1'b1; convReady = 1'b1;
    repeat (3) @(negedge clk);
    pixValid = 1'b0;
    checkOutput("pre-reset no output yet", convValid, 0);
    rst = 1'b1;
    #1;
    checkOutput("mid reset valid", convValid, 0);
    checkOutput("mid reset data", convData, 0);
    checkOutput("mid reset count", edgeCnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post reset ready", pixReady, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (convValid) seen++;
    end
    checkOutput("stale results after reset", seen, 0);
    checkOutput("post reset data held", convData, 0);
  endtask

  initial begin
    vec_t edgeVec;
    rst = 1'b1; th = '0; kern = '0; mag = 1'b0; outSel = 1'b0;
    pixData = '0; pixValid = 1'b0; convReady = 1'b0; cntClr = 1'b0;
    th12 = '0; kern12 = '0; mag12 = 1'b1; outSel12 = 1'b1;
    pixData12 = '0; pixValid12 = 1'b0; convReady12 = 1'b1; cntClr12 = 1'b0;

    addVec("flat field",         0, 0, 0, 1,   mk(100,100,100,100,100,100,100,100,100), 8'h00);
    addVec("vert sobel L2 bin",  0, 0, 0, 255, mk(255,0,0,255,0,0,255,0,0), 8'hFF);
    addVec("vert prewitt L2 bin",1, 0, 0, 255, mk(255,0,0,255,0,0,255,0,0), 8'hFF);
    addVec("vert scharr L2 bin", 2, 0, 0, 255, mk(255,0,0,255,0,0,255,0,0), 8'hFF);
    addVec("vert sobel L1 grey", 0, 1, 1, 255, mk(255,0,0,255,0,0,255,0,0), 8'hFF);
    addVec("vert prewitt L1 grey",1,1, 1, 255, mk(255,0,0,255,0,0,255,0,0), 8'hFF);
    addVec("vert scharr L1 grey",2, 1, 1, 255, mk(255,0,0,255,0,0,255,0,0), 8'hFF);
    addVec("L2 th 20",           0, 0, 0, 20,  mk(0,0,0,10,0,0,0,0,0), 8'h00);
    addVec("L2 th 19",           0, 0, 0, 19,  mk(0,0,0,10,0,0,0,0,0), 8'hFF);
    addVec("L1 th 20",           0, 1, 0, 20,  mk(0,0,0,10,0,0,0,0,0), 8'h00);
    addVec("L1 th 19",           0, 1, 0, 19,  mk(0,0,0,10,0,0,0,0,0), 8'hFF);
    addVec("p3 L2 grey",         0, 0, 1, 0,   mk(0,0,0,10,0,0,0,0,0), 8'h01);
    addVec("p3 L1 grey",         0, 1, 1, 0,   mk(0,0,0,10,0,0,0,0,0), 8'h14);
    addVec("prewitt gy L1 grey", 1, 1, 1, 0,   mk(0,50,0,0,0,0,0,0,0), 8'h32);
    addVec("kern3 L1 grey",      3, 1, 1, 0,   mk(30,0,0,0,0,0,0,0,0), 8'h3C);
    addVec("kern3 L2 grey",      3, 0, 1, 0,   mk(30,0,0,0,0,0,0,0,0), 8'h07);
    addVec("neg gx L1 grey",     0, 1, 1, 0,   mk(0,0,40,0,0,0,0,0,0), 8'h50);
    addVec("neg gx L2 grey",     0, 0, 1, 0,   mk(0,0,0,0,0,100,0,0,0), 8'h9C);
    addVec("scharr L2 grey sat", 2, 0, 1, 0,   mk(0,0,0,0,0,0,0,0,255), 8'hFF);

    #1;
    checkOutput("reset valid", convValid, 0);
    checkOutput("reset data", convData, 0);
    checkOutput("reset count", edgeCnt, 0);
    checkOutput("reset ready", pixReady, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    convReady = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 1'b0);

    @(negedge clk);
    cntClr = 1'b1;
    @(negedge clk);
    cntClr = 1'b0;
    expCnt = 0;
    checkOutput("counter cleared", edgeCnt, 0);
    edgeVec = vecs[1];
    for (int i = 0; i < 5; i++) applyStimulus(edgeVec, 1'b0);
    checkOutput("counter after 5 edges", edgeCnt, 5);
    applyStimulus(edgeVec, 1'b1);
    checkOutput("counter clear beats increment", edgeCnt, 0);
    for (int i = 0; i < 2; i++) applyStimulus(edgeVec, 1'b0);
    checkOutput("counter after 2 more", edgeCnt, 2);

    backpressureRun();
    perPixelRun();
    resetRun();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
